// File: rtl/sample_avg_ctrl.sv
// ---------------------------------------------------------------------------
// sample_avg_ctrl
//
// Sensor sampling sequencer with averaging. A start request launches a run of
// N = 2**SAMPLES_LOG2 readings. Each reading is preceded by DELAY_CYCLES idle
// clocks and a one-cycle sample_req pulse. The sequencer then waits as long
// as needed for the sensor's sample_valid. The readings are summed, and the
// truncated mean is presented on avg_out with a one-cycle avg_valid pulse.
//
// Configuration macro:
//   CONTINUOUS_EN  when defined, each finished average immediately starts the
//                  next run (busy stays high until rst). HOLD is unreachable
//                  and start is only honoured in IDLE. When undefined, one
//                  average is produced per start, and the block parks in HOLD.
//
// Ports:
//   clk           in   1       clock, rising edge
//   rst           in   1       synchronous, active-high reset; aborts any run
//   start         in   1       begin an averaging run (IDLE or HOLD only)
//   sample_req    out  1       one-cycle request for a sensor reading
//   sample_valid  in   1       sensor reading present on sample_in
//   sample_in     in   DATA_W  unsigned sensor reading
//   busy          out  1       high while a run is in progress
//   avg_out       out  DATA_W  last computed average, held until next update
//   avg_valid     out  1       one-cycle pulse when avg_out is updated
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module sample_avg_ctrl #(
  parameter int DATA_W       = 12,
  parameter int SAMPLES_LOG2 = 3,
  parameter int DELAY_W      = 16,
  parameter int DELAY_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              sample_req,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic              busy,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid
);

  // The accumulator is wide enough for N full-scale readings, so it can never wrap.
  localparam int ACC_W = DATA_W + SAMPLES_LOG2;

  localparam logic [DELAY_W-1:0]      DLY_LOAD = DELAY_W'(DELAY_CYCLES);
  localparam logic [DELAY_W-1:0]      DLY_LAST = DELAY_W'(1);
  localparam logic [SAMPLES_LOG2-1:0] CNT_LAST = '1;
  localparam logic [SAMPLES_LOG2-1:0] CNT_ONE  = SAMPLES_LOG2'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;

  logic [2:0]              state;
  logic [2:0]              state_next;
  logic [DELAY_W-1:0]      dly;
  logic [SAMPLES_LOG2-1:0] cnt;
  logic [ACC_W-1:0]        accum;
  logic [ACC_W-1:0]        accum_sum;
  logic                    run_begin;
  logic                    sample_take;
  logic                    last_sample;

  // Running sum including the reading arriving this cycle. The top DATA_W
  // bits of this sum form the truncated average of the final reading.
  assign accum_sum   = accum + ACC_W'(sample_in);
  assign sample_take = (state == S_CAPTURE) && sample_valid;
  assign last_sample = (cnt == CNT_LAST);

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaulting every always_comb output first prevents inferred
    // latches on paths that do not assign it.
    state_next = state;
    run_begin  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_WAIT;
          run_begin  = 1'b1;
        end
      end
      // dly counts DELAY_CYCLES..1. The cycle that sees 1 is the last WAIT cycle.
      S_WAIT: begin
        if (dly == DLY_LAST) state_next = S_REQ;
      end
      // A reading that arrives while sample_req is asserted is not accepted.
      // CAPTURE starts on the following cycle.
      S_REQ: state_next = S_CAPTURE;
      S_CAPTURE: begin
        if (sample_valid) state_next = last_sample ? S_OUTPUT : S_WAIT;
      end
`ifdef CONTINUOUS_EN
      S_OUTPUT: begin
        state_next = S_WAIT;
        run_begin  = 1'b1;
      end
`else
      S_OUTPUT: state_next = S_HOLD;
      S_HOLD: begin
        if (start) begin
          state_next = S_WAIT;
          run_begin  = 1'b1;
        end
      end
`endif
      // Unused encodings (including HOLD in continuous builds) fall back to IDLE.
      default: state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // State, datapath and registered outputs
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sample_req <= 1'b0;
      busy       <= 1'b0;
      avg_valid  <= 1'b0;
      avg_out    <= '0;
      accum      <= '0;
      cnt        <= '0;
      dly        <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // pre-edge values regardless of statement order.
      state <= state_next;

      // Outputs are decoded from the state being entered. This makes each
      // output change on the same edge as the state transition.
      sample_req <= (state_next == S_REQ);
      avg_valid  <= (state_next == S_OUTPUT);
      busy       <= (state_next == S_WAIT)    || (state_next == S_REQ) ||
                    (state_next == S_CAPTURE) || (state_next == S_OUTPUT);

      if (run_begin) begin
        accum <= '0;
        cnt   <= '0;
        dly   <= DLY_LOAD;
      end else if (state == S_WAIT) begin
        dly <= dly - DLY_LAST;
      end

      if (sample_take) begin
        accum <= accum_sum;
        if (last_sample) begin
          avg_out <= accum_sum[ACC_W-1:SAMPLES_LOG2];
        end else begin
          cnt <= cnt + CNT_ONE;
          dly <= DLY_LOAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_avg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sample_avg_ctrl
//
// Self-checking bench for sample_avg_ctrl, configured with DATA_W=12,
// SAMPLES_LOG2=2 and DELAY_CYCLES=4. A sensor model answers every sample_req,
// optionally after a stall. It can optionally inject spurious sample_valid
// pulses while the design is in WAIT/REQ, and it can optionally pulse start
// while the design is busy. The expected average is the plain integer mean of
// the readings that were actually offered in CAPTURE. Request latency is
// measured in clock edges from the triggering edge.
// ---------------------------------------------------------------------------
module tb_sample_avg_ctrl;

  localparam int DATA_W       = 12;
  localparam int SAMPLES_LOG2 = 2;
  localparam int DELAY_W      = 16;
  localparam int DELAY_CYCLES = 4;
  localparam int N            = 1 << SAMPLES_LOG2;
`ifdef CONTINUOUS_EN
  localparam logic CONT = 1'b1;
`else
  localparam logic CONT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_req;
  logic              busy;
  logic [DATA_W-1:0] avg_out;
  logic              avg_valid;

  sample_avg_ctrl #(
    .DATA_W       (DATA_W),
    .SAMPLES_LOG2 (SAMPLES_LOG2),
    .DELAY_W      (DELAY_W),
    .DELAY_CYCLES (DELAY_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sample_req   (sample_req),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .busy         (busy),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse counters, sampled on the falling edge away from register updates.
  int av_cnt       = 0;
  int req_cnt      = 0;
  int busy_low_cnt = 0;
  always @(negedge clk) begin
    if (avg_valid === 1'b1) av_cnt++;
    if (sample_req === 1'b1) req_cnt++;
    if (rst === 1'b0 && busy !== 1'b1) busy_low_cnt++;
  end

  logic [DATA_W-1:0] smp [N];   // readings for the next run
  logic [DATA_W-1:0] exp_avg;   // value avg_out must be holding

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called immediately after the triggering edge. Expects sample_req exactly
  // DELAY_CYCLES edges later, with busy high and avg_out still holding.
  task automatic wait_req(input string name, input bit noise, input bit poke);
    int n = 0;
    while (sample_req !== 1'b1 && n < 200) begin
      if (noise) begin
        sample_valid = 1'b1;
        sample_in    = 12'd999;
      end
      if (poke) start = 1'b1;
      tick;
      n++;
    end
    n_tests++;
    if (sample_req !== 1'b1 || n != DELAY_CYCLES) begin
      n_fail++;
      $display("FAIL %s req_latency: got %0d edges (sample_req=%b), want %0d",
               name, n, sample_req, DELAY_CYCLES);
    end
    n_tests++;
    if (busy !== 1'b1 || avg_out !== exp_avg || avg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s held_in_run: busy=%b avg_out=%0d avg_valid=%b, want busy=1 avg_out=%0d avg_valid=0",
               name, busy, avg_out, avg_valid, exp_avg);
    end
  endtask

  // Called while sample_req is visible. Lets the REQ cycle pass, optionally
  // with a spurious reading present, then stalls dly cycles, then delivers v.
  task automatic capture(input string name, input logic [DATA_W-1:0] v,
                         input int dly, input bit noise, input bit poke);
    if (noise) begin
      sample_valid = 1'b1;
      sample_in    = 12'd999;
    end
    if (poke) start = 1'b1;
    tick;
    sample_valid = 1'b0;
    start        = 1'b0;
    n_tests++;
    if (sample_req !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s req_pulse: sample_req=%b busy=%b, want 0 1", name, sample_req, busy);
    end
    for (int i = 0; i < dly; i++) tick;
    n_tests++;
    if (sample_req !== 1'b0 || busy !== 1'b1 || avg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s capture_stall: sample_req=%b busy=%b avg_valid=%b, want 0 1 0",
               name, sample_req, busy, avg_valid);
    end
    sample_valid = 1'b1;
    sample_in    = v;
    tick;
    sample_valid = 1'b0;
    sample_in    = 12'($urandom);
  endtask

  // One complete averaging run over smp[].
  task automatic run_avg(input string name, input int cap_dly, input bit noise,
                         input bit poke, input bit do_start);
    int sum = 0;
    int av0 = av_cnt;
    int rq0 = req_cnt;
    for (int i = 0; i < N; i++) sum += int'(smp[i]);
    if (do_start) begin
      start = 1'b1;
      tick;
      start = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      wait_req(name, noise, poke);
      capture(name, smp[i], cap_dly, noise, poke);
    end
    exp_avg = 12'(sum / N);
    n_tests++;
    if (avg_valid !== 1'b1 || avg_out !== exp_avg) begin
      n_fail++;
      $display("FAIL %s avg_result: avg_valid=%b avg_out=%0d, want 1 %0d",
               name, avg_valid, avg_out, exp_avg);
    end
    tick;
    n_tests++;
    if (avg_valid !== 1'b0 || avg_out !== exp_avg || busy !== CONT ||
        (av_cnt - av0) != 1 || (req_cnt - rq0) != N) begin
      n_fail++;
      $display("FAIL %s after_run: avg_valid=%b avg_out=%0d busy=%b pulses=%0d reqs=%0d, want 0 %0d %b 1 %0d",
               name, avg_valid, avg_out, busy, av_cnt - av0, req_cnt - rq0, exp_avg, CONT, N);
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b1;   // rst must win over a simultaneous start
    tick;
    tick;
    n_tests++;
    if (busy !== 1'b0 || sample_req !== 1'b0 || avg_valid !== 1'b0 || avg_out !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b req=%b avg_valid=%b avg_out=%0d, want all 0",
               busy, sample_req, avg_valid, avg_out);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick;
    tick;
    n_tests++;
    if (busy !== 1'b0 || sample_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b req=%b, want 0 0", busy, sample_req);
    end
    exp_avg = '0;
  endtask

  task automatic test_basic;
    smp[0] = 12'd10; smp[1] = 12'd20; smp[2] = 12'd30; smp[3] = 12'd40;
    run_avg("basic", 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_boundary;
    for (int i = 0; i < N; i++) smp[i] = 12'd4095;
    run_avg("full_scale", 1, 1'b0, 1'b0, 1'b1);
    smp[0] = 12'd1; smp[1] = 12'd1; smp[2] = 12'd1; smp[3] = 12'd2;
    run_avg("truncate", 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_ignored_valid;
    smp[0] = 12'd100; smp[1] = 12'd200; smp[2] = 12'd300; smp[3] = 12'd400;
    run_avg("ignored_valid", 7, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_busy_start;
    for (int i = 0; i < N; i++) smp[i] = 12'($urandom);
    run_avg("busy_start", 2, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_rst_abort;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_req("abort", 1'b0, 1'b0);
    capture("abort", 12'd50, 0, 1'b0, 1'b0);
    wait_req("abort", 1'b0, 1'b0);
    capture("abort", 12'd60, 0, 1'b0, 1'b0);
    wait_req("abort", 1'b0, 1'b0);
    tick;           // now in the third CAPTURE
    rst = 1'b1;
    tick;
    n_tests++;
    if (busy !== 1'b0 || avg_out !== '0 || avg_valid !== 1'b0 || sample_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort: busy=%b avg_out=%0d avg_valid=%b req=%b, want all 0",
               busy, avg_out, avg_valid, sample_req);
    end
    rst     = 1'b0;
    exp_avg = '0;
    for (int i = 0; i < N; i++) smp[i] = 12'd8;
    run_avg("after_abort", 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) smp[i] = 12'($urandom);
      run_avg("random", int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), 1'b1);
    end
  endtask

  task automatic test_continuous;
    int low0;
    for (int i = 0; i < N; i++) smp[i] = 12'd100;
    run_avg("cont_first", 1, 1'b0, 1'b0, 1'b1);
    low0 = busy_low_cnt;
    for (int i = 0; i < N; i++) smp[i] = 12'd200;
    run_avg("cont_second", 0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (busy_low_cnt != low0) begin
      n_fail++;
      $display("FAIL cont_busy: busy dropped %0d cycles, want 0", busy_low_cnt - low0);
    end
  endtask

  initial begin
    test_reset;
`ifdef CONTINUOUS_EN
    test_continuous;
    test_rst_abort;
`else
    test_basic;
    test_boundary;
    test_ignored_valid;
    test_busy_start;
    test_rst_abort;
    test_random;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
